// File: rtl/prog_fetch_if.sv
// Load channel and decoder channel between prog_fetch and its neighbours.
// Signal names keep their i_/o_ prefixes as seen from prog_fetch.
interface prog_fetch_if;
  logic       i_load_mode;
  logic       i_load_valid;
  logic [2:0] i_load_instr;
  logic       o_load_ready;
  logic       i_con_pcincr;
  logic [2:0] i_con_mux8;
  logic [2:0] o_instr;
  logic [2:0] o_data_count;

  modport master (
    output i_load_mode, i_load_valid, i_load_instr, i_con_pcincr, i_con_mux8,
    input  o_load_ready, o_instr, o_data_count
  );

  modport slave (
    input  i_load_mode, i_load_valid, i_load_instr, i_con_pcincr, i_con_mux8,
    output o_load_ready, o_instr, o_data_count
  );
endinterface

// File: rtl/prog_fetch.sv
// Program store and instruction fetch for the bit-serial datapath.
// state | meaning
// IDLE  | waiting for load or run request; outputs NOP
// LOAD  | writing opcodes from address 0, one per handshake
// RUN   | presenting mem[pc] to decoder, advancing on pcincr
// HALT  | ran past the last opcode without loop; waits for run drop
module prog_fetch #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  prog_fetch_if.slave   bus,
  input  logic          i_run,
  input  logic          i_loop,
  output logic [AW-1:0] o_pc,
  output logic [AW:0]   o_prog_len,
  output logic          o_busy,
  output logic          o_halted
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW:0]   prog_len;
  logic [2:0]    mem [DEPTH];

  logic load_ready;
  logic load_acc;
  logic at_last;

  assign load_ready = (state == S_LOAD) && (prog_len < DEPTH_L);
  assign load_acc   = load_ready && bus.i_load_valid;
  assign at_last    = ({1'b0, pc} == (prog_len - 1'b1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      prog_len <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_load_mode) begin
            state    <= S_LOAD;
            prog_len <= '0;
          end else if (i_run && (prog_len != '0)) begin
            state <= S_RUN;
            pc    <= '0;
          end
        end
        S_LOAD: begin
          // a final accept still lands in the cycle load_mode drops
          if (load_acc) begin
            mem[prog_len[AW-1:0]] <= bus.i_load_instr;
            prog_len              <= prog_len + 1'b1;
          end
          if (!bus.i_load_mode) state <= S_IDLE;
        end
        S_RUN: begin
          if (!i_run) begin
            state <= S_IDLE;
            pc    <= '0;
          end else if (bus.i_con_pcincr) begin
            if (!at_last)    pc <= pc + 1'b1;
            else if (i_loop) pc <= '0;
            else             state <= S_HALT;
          end
        end
        S_HALT: begin
          if (!i_run) begin
            state <= S_IDLE;
            pc    <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_load_ready = load_ready;
  assign bus.o_instr      = (state == S_RUN) ? mem[pc] : 3'b000;
  assign bus.o_data_count = (state == S_RUN) ? (bus.i_con_mux8 + 3'd1) : 3'd0;
  assign o_pc             = pc;
  assign o_prog_len       = prog_len;
  assign o_busy           = (state == S_RUN);
  assign o_halted         = (state == S_HALT);

endmodule

// File: tb/tb_prog_fetch.sv
// Self-checking bench for prog_fetch: loaded opcodes go into a queue and are
// popped as the fetch unit presents them in RUN.
module tb_prog_fetch;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_run = 1'b0;
  logic       i_loop = 1'b0;
  logic [3:0] o_pc;
  logic [4:0] o_prog_len;
  logic       o_busy;
  logic       o_halted;

  prog_fetch_if bus();

  int total = 0;
  int bad = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_op;

  always #5 i_clk = ~i_clk;

  prog_fetch #(.DEPTH(16), .AW(4)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .bus        (bus),
    .i_run      (i_run),
    .i_loop     (i_loop),
    .o_pc       (o_pc),
    .o_prog_len (o_prog_len),
    .o_busy     (o_busy),
    .o_halted   (o_halted)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pop_exp();
    if (exp_q.size() == 0) begin
      exp_op = 3'bxxx;
      total++; bad++;
      $display("FAIL scoreboard_empty no expected opcode queued");
    end else begin
      exp_op = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    bus.i_con_mux8 = 3'd3;
    i_rst = 1'b1;
    #12;
    total++; if (bus.o_instr !== 3'b000) begin bad++; $display("FAIL reset_instr got=%b exp=000", bus.o_instr); end
    total++; if (bus.o_data_count !== 3'd0) begin bad++; $display("FAIL reset_data_count got=%0d exp=0", bus.o_data_count); end
    total++; if (o_pc !== 4'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", o_pc); end
    total++; if (o_prog_len !== 5'd0) begin bad++; $display("FAIL reset_prog_len got=%0d exp=0", o_prog_len); end
    total++; if (bus.o_load_ready !== 1'b0) begin bad++; $display("FAIL reset_load_ready got=%b exp=0", bus.o_load_ready); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    total++; if (o_halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", o_halted); end
    @(negedge i_clk);
    i_rst = 1'b0;
    bus.i_con_mux8 = 3'd0;
    tick();
  endtask

  task automatic test_load_run_halt();
    bus.i_load_mode = 1'b1;
    tick();
    total++; if (bus.o_load_ready !== 1'b1) begin bad++; $display("FAIL load_ready_enter got=%b exp=1", bus.o_load_ready); end
    bus.i_load_valid = 1'b1;
    bus.i_load_instr = 3'b111; exp_q.push_back(3'b111); tick();
    bus.i_load_instr = 3'b100; exp_q.push_back(3'b100); tick();
    bus.i_load_instr = 3'b001; exp_q.push_back(3'b001);
    bus.i_load_mode = 1'b0;
    tick();
    bus.i_load_valid = 1'b0;
    total++; if (o_prog_len !== 5'd3) begin bad++; $display("FAIL load3_prog_len got=%0d exp=3", o_prog_len); end
    total++; if (bus.o_load_ready !== 1'b0) begin bad++; $display("FAIL load3_ready_idle got=%b exp=0", bus.o_load_ready); end
    i_run = 1'b1;
    tick();
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL run_busy got=%b exp=1", o_busy); end
    for (int k = 0; k < 3; k++) begin
      pop_exp();
      total++; if (bus.o_instr !== exp_op) begin bad++; $display("FAIL run_instr[%0d] got=%b exp=%b", k, bus.o_instr, exp_op); end
      bus.i_con_pcincr = 1'b1;
      tick();
      bus.i_con_pcincr = 1'b0;
    end
    total++; if (o_halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", o_halted); end
    total++; if (o_pc !== 4'd2) begin bad++; $display("FAIL halt_pc got=%0d exp=2", o_pc); end
    total++; if (bus.o_instr !== 3'b000) begin bad++; $display("FAIL halt_instr got=%b exp=000", bus.o_instr); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL halt_busy got=%b exp=0", o_busy); end
    i_run = 1'b0;
    tick();
    total++; if (o_halted !== 1'b0) begin bad++; $display("FAIL halt_exit got=%b exp=0", o_halted); end
    total++; if (o_pc !== 4'd0) begin bad++; $display("FAIL halt_exit_pc got=%0d exp=0", o_pc); end
  endtask

  task automatic test_back_to_back_loop();
    exp_q.push_back(3'b111); exp_q.push_back(3'b100); exp_q.push_back(3'b001);
    i_loop = 1'b1;
    i_run = 1'b1;
    tick();
    bus.i_con_pcincr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pop_exp();
      total++; if (bus.o_instr !== exp_op) begin bad++; $display("FAIL loop_instr[%0d] got=%b exp=%b", k, bus.o_instr, exp_op); end
      total++; if (o_pc !== 4'(k)) begin bad++; $display("FAIL loop_pc[%0d] got=%0d exp=%0d", k, o_pc, k); end
      tick();
    end
    bus.i_con_pcincr = 1'b0;
    total++; if (o_pc !== 4'd0) begin bad++; $display("FAIL loop_wrap_pc got=%0d exp=0", o_pc); end
    total++; if (bus.o_instr !== 3'b111) begin bad++; $display("FAIL loop_wrap_instr got=%b exp=111", bus.o_instr); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL loop_wrap_busy got=%b exp=1", o_busy); end
    i_run = 1'b0;
    i_loop = 1'b0;
    tick();
  endtask

  task automatic test_full();
    exp_q.delete();
    bus.i_load_mode = 1'b1;
    tick();
    bus.i_load_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.i_load_instr = (i < 16) ? 3'((i + 1) % 8) : 3'b110;
      #1;
      total++; if (bus.o_load_ready !== (i < 16)) begin bad++; $display("FAIL full_ready[%0d] got=%b exp=%b", i, bus.o_load_ready, (i < 16)); end
      if (i < 16) exp_q.push_back(3'((i + 1) % 8));
      tick();
    end
    bus.i_load_valid = 1'b0;
    total++; if (o_prog_len !== 5'd16) begin bad++; $display("FAIL full_prog_len got=%0d exp=16", o_prog_len); end
    bus.i_load_mode = 1'b0;
    tick();
    i_run = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      pop_exp();
      total++; if (bus.o_instr !== exp_op) begin bad++; $display("FAIL full_instr[%0d] got=%b exp=%b", i, bus.o_instr, exp_op); end
      bus.i_con_pcincr = 1'b1;
      tick();
      bus.i_con_pcincr = 1'b0;
    end
    total++; if (o_halted !== 1'b1) begin bad++; $display("FAIL full_halt got=%b exp=1", o_halted); end
    total++; if (o_pc !== 4'd15) begin bad++; $display("FAIL full_halt_pc got=%0d exp=15", o_pc); end
    i_run = 1'b0;
    tick();
  endtask

  task automatic test_data_count();
    i_run = 1'b1;
    tick();
    for (int m = 0; m < 8; m++) begin
      bus.i_con_mux8 = 3'(m);
      #1;
      total++; if (bus.o_data_count !== 3'((m + 1) % 8)) begin bad++; $display("FAIL run_data_count[%0d] got=%0d exp=%0d", m, bus.o_data_count, (m + 1) % 8); end
    end
    i_run = 1'b0;
    tick();
    for (int m = 0; m < 8; m++) begin
      bus.i_con_mux8 = 3'(m);
      #1;
      total++; if (bus.o_data_count !== 3'd0) begin bad++; $display("FAIL idle_data_count[%0d] got=%0d exp=0", m, bus.o_data_count); end
    end
    bus.i_con_mux8 = 3'd0;
  endtask

  task automatic test_corners();
    exp_q.delete();
    @(negedge i_clk);
    i_rst = 1'b1;
    #2;
    i_rst = 1'b0;
    i_run = 1'b1;
    tick();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL empty_run_busy got=%b exp=0", o_busy); end
    total++; if (bus.o_load_ready !== 1'b0) begin bad++; $display("FAIL empty_run_ready got=%b exp=0", bus.o_load_ready); end
    bus.i_load_mode = 1'b1;
    tick();
    total++; if (bus.o_load_ready !== 1'b1) begin bad++; $display("FAIL load_prio_ready got=%b exp=1", bus.o_load_ready); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL load_prio_busy got=%b exp=0", o_busy); end
    bus.i_load_valid = 1'b1;
    bus.i_load_instr = 3'b010; exp_q.push_back(3'b010); tick();
    bus.i_load_instr = 3'b011; exp_q.push_back(3'b011); tick();
    bus.i_load_instr = 3'b101; exp_q.push_back(3'b101); tick();
    bus.i_load_valid = 1'b0;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL load_ignores_run got=%b exp=0", o_busy); end
    bus.i_load_mode = 1'b0;
    tick();
    tick();
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL corner_run_busy got=%b exp=1", o_busy); end
    pop_exp();
    total++; if (bus.o_instr !== exp_op) begin bad++; $display("FAIL corner_instr0 got=%b exp=%b", bus.o_instr, exp_op); end
    bus.i_con_pcincr = 1'b1;
    tick();
    bus.i_con_pcincr = 1'b0;
    pop_exp();
    total++; if (o_pc !== 4'd1) begin bad++; $display("FAIL corner_pc1 got=%0d exp=1", o_pc); end
    total++; if (bus.o_instr !== exp_op) begin bad++; $display("FAIL corner_instr1 got=%b exp=%b", bus.o_instr, exp_op); end
    i_run = 1'b0;
    bus.i_con_pcincr = 1'b1;
    tick();
    bus.i_con_pcincr = 1'b0;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", o_busy); end
    total++; if (o_pc !== 4'd0) begin bad++; $display("FAIL abort_pc got=%0d exp=0", o_pc); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_run();
    bus.i_load_mode = 1'b1;
    tick();
    bus.i_load_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.i_load_instr = 3'(7 - i);
      tick();
    end
    bus.i_load_valid = 1'b0;
    bus.i_load_mode = 1'b0;
    tick();
    i_run = 1'b1;
    tick();
    bus.i_con_pcincr = 1'b1;
    tick(); tick(); tick();
    bus.i_con_pcincr = 1'b0;
    bus.i_con_mux8 = 3'd5;
    #1;
    total++; if (o_pc !== 4'd3) begin bad++; $display("FAIL midrun_pc got=%0d exp=3", o_pc); end
    total++; if (bus.o_instr !== 3'b100) begin bad++; $display("FAIL midrun_instr got=%b exp=100", bus.o_instr); end
    #1;
    i_rst = 1'b1;
    #1;
    total++; if (o_pc !== 4'd0) begin bad++; $display("FAIL async_pc got=%0d exp=0", o_pc); end
    total++; if (o_prog_len !== 5'd0) begin bad++; $display("FAIL async_prog_len got=%0d exp=0", o_prog_len); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b exp=0", o_busy); end
    total++; if (bus.o_instr !== 3'b000) begin bad++; $display("FAIL async_instr got=%b exp=000", bus.o_instr); end
    total++; if (bus.o_data_count !== 3'd0) begin bad++; $display("FAIL async_data_count got=%0d exp=0", bus.o_data_count); end
    i_run = 1'b0;
    bus.i_con_mux8 = 3'd0;
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();
  endtask

  initial begin
    bus.i_load_mode  = 1'b0;
    bus.i_load_valid = 1'b0;
    bus.i_load_instr = 3'b000;
    bus.i_con_pcincr = 1'b0;
    bus.i_con_mux8   = 3'd0;
    test_reset();
    test_load_run_halt();
    test_back_to_back_loop();
    test_full();
    test_data_count();
    test_corners();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
